// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, no preemption, one dead cycle between owners.
// Optional hold limit compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int  NUM_REQ  = 4,
  parameter int  MAX_HOLD = 16,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic               timeout_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ must be within 2..16");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be within 2..255");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     sel_s;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]           cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  // Nearest requester above 'last' with wrap; scanning far-to-near lets the nearest win.
  function automatic logic [IDX_W-1:0] next_owner(input logic [NUM_REQ-1:0] req,
                                                  input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    sel = {IDX_W{1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[cand]) begin
        sel = cand;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  assign sel_s = next_owner(req_i, last_q);

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = BUSY;
          idx_d   = sel_s;
          last_d  = sel_s;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (!req_i[idx_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // A voluntary release takes precedence over revocation on the same edge.
        else if (cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        else begin
          valid_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (valid_d) begin
      gnt_d = onehot(idx_d);
    end else begin
      gnt_d = {NUM_REQ{1'b0}};
    end
  end

  // State and output registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_W{1'b0}};
      last_q    <= IDX_W'(NUM_REQ - 1);
      valid_q   <= 1'b0;
      gnt_q     <= {NUM_REQ{1'b0}};
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      gnt_q     <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a driver pushes reference-model expectations, a monitor pops and compares.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         arst_i;
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         gnt_valid_o;
  logic         timeout_o;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .arst_i(arst_i), .req_i(req_i), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .gnt_valid_o(gnt_valid_o), .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   idx;
    logic         valid;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: current owner (-1 = none), last winner, cycles held by owner.
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_held  = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, output exp_t e);
    bit to;
    to = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last + i) % N;
          if (((int'(r) >> c) & 1) != 0) begin
            m_owner = c;
            m_last  = c;
            m_held  = 1;
            break;
          end
        end
      end
    end else if (((int'(r) >> m_owner) & 1) == 0) begin
      m_owner = -1;
    end else if (TO_EN && m_held == MH) begin
      m_owner = -1;
      to      = 1'b1;
    end else begin
      m_held++;
    end
    e.valid = (m_owner >= 0);
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.idx   = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    e.to    = to;
  endtask

  task automatic apply(input logic [N-1:0] r);
    exp_t e;
    @(negedge clk);
    req_i = r;
    model_step(r, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_i = 4'b1111;
    #2;
    arst_i = 1'b1;
    #1;
    check("rst_gnt",   int'(gnt_o),       0);
    check("rst_idx",   int'(gnt_idx_o),   0);
    check("rst_valid", int'(gnt_valid_o), 0);
    check("rst_to",    int'(timeout_o),   0);
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    @(posedge clk);
    #2;
    arst_i = 1'b0;
  endtask

  // Monitor: compares every registered output cycle against the queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("gnt",     int'(gnt_o),       int'(mon_e.gnt));
      check("valid",   int'(gnt_valid_o), int'(mon_e.valid));
      check("timeout", int'(timeout_o),   int'(mon_e.to));
      check("onehot",  int'($countones(gnt_o) <= 1), 1);
      check("valid_or", int'(gnt_valid_o), int'(|gnt_o));
      if (mon_e.valid) begin
        check("idx", int'(gnt_idx_o), int'(mon_e.idx));
      end
    end
  end

  initial begin
    arst_i = 1'b1;
    req_i  = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    arst_i = 1'b0;

    // Reset mid-grant drops the grant immediately; requester 0 wins first afterwards.
    apply(4'b0010);
    apply(4'b0010);
    do_reset();
    apply(4'b1111);
    check("first_gnt", int'(gnt_o), 1);
    check("first_idx", int'(gnt_idx_o), 0);

    // Rotation with a dead cycle between owners.
    for (int k = 0; k < N; k++) begin
      apply(4'b1111);
      apply(4'(4'b1111 & ~(4'b0001 << k)));
      check("rot_dead", int'(gnt_o), 0);
      apply(4'b1111);
      check("rot_order", int'(gnt_o), 1 << ((k + 1) % N));
    end

    // Wrap and skip from last_idx=2.
    apply(4'b0000);
    apply(4'b0100);
    check("wrap_g2", int'(gnt_o), 4);
    apply(4'b0000);
    apply(4'b0011);
    check("wrap_g0", int'(gnt_o), 1);
    apply(4'b0010);
    apply(4'b0010);
    check("skip_g1", int'(gnt_o), 2);

    // No preemption: requester 3 pulses while 1 owns and is never granted.
    for (int k = 0; k < 3; k++) begin
      apply(4'b1010);
      check("nopre_hold", int'(gnt_o), 2);
    end
    apply(4'b0000);
    check("nopre_rel", int'(gnt_o), 0);
    apply(4'b0000);
    check("nopre_no3", int'(gnt_o), 0);

    // Hold limit behaviour.
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < MH; k++) begin
      apply(4'b0101);
      check("to_hold", int'(gnt_o), 1);
      check("to_quiet", int'(timeout_o), 0);
    end
    apply(4'b0101);
    check("to_revoke_gnt", int'(gnt_o), 0);
    check("to_pulse", int'(timeout_o), 1);
    apply(4'b0101);
    check("to_next", int'(gnt_o), 4);
    check("to_clear", int'(timeout_o), 0);
`else
    for (int k = 0; k < 100; k++) begin
      apply(4'b0101);
      check("hold_forever", int'(gnt_o), 1);
      check("no_timeout", int'(timeout_o), 0);
    end
`endif

    // Random requests against the reference model.
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      apply(4'($urandom_range(0, 15)));
    end
    apply(4'b0000);
    apply(4'b0000);
    #10;
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
